// File: rtl/ag32gbd_pkg.sv
// Shared constants and drain-FSM state type for the camera cartridge register front end.
package ag32gbd_pkg;

    localparam logic [2:0] CART_RAM_A15_13   = 3'b101;
    localparam logic [4:0] DEFAULT_REG_BANK  = 5'h10;
    localparam logic [9:0] DEFAULT_BRAM_BASE = 10'h200;
    localparam int         REG_ALIAS_BITS    = 7;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } drain_state_t;

endpackage

// File: rtl/ag32gbd_sync_edge.sv
// Multi-flop synchroniser for one asynchronous cart-side signal, with edge pulses
// derived from the last two synchronised samples.
module ag32gbd_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] chain_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            chain_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q  <= RESET_VAL;
        end else begin
            chain_q <= {chain_q[SYNC_STAGES-2:0], d_i};
            prev_q  <= chain_q[SYNC_STAGES-1];
        end
    end

    assign level_o = chain_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~prev_q;
    assign fall_o  = ~level_o & prev_q;

endmodule

// File: rtl/ag32gbd_regfile.sv
// Cartridge-bus register bank for the camera core: control registers, read-back,
// and a queued BRAM write path drained through a req/ack handshake.
module ag32gbd_regfile
    import ag32gbd_pkg::*;
#(
    parameter int         NUM_REGS     = 6,
    parameter logic [4:0] REG_BANK_ID  = DEFAULT_REG_BANK,
    parameter logic [9:0] BRAM_BASE    = DEFAULT_BRAM_BASE,
    parameter int         SYNC_STAGES  = 2,
    parameter int         FIFO_DEPTH   = 4,
    parameter bit         READBACK_ALL = 1'b1
) (
    input  logic                  sys_clock,
    input  logic                  sys_resetn,
    input  logic [15:0]           Cart_a,
    input  logic [7:0]            Cart_d,
    input  logic                  Cart_nRD,
    input  logic                  Cart_nWR,
    input  logic                  Cart_nCS,
    input  logic [4:0]            Ram_bank_id,
    input  logic                  Sig_CamCaptureFinish,
    input  logic                  Bram_Ack,
    output logic                  Reg_OutputValid,
    output logic [7:0]            Reg_OutputData,
    output logic                  Bram_Req_Write,
    output logic [9:0]            Bram_Addr,
    output logic [7:0]            Bram_Data,
    output logic [8*NUM_REGS-1:0] Reg_Flat,
    output logic                  Cam_Capture,
    output logic                  Fifo_Overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [REG_ALIAS_BITS-1:0] NUM_REGS_OFF = REG_ALIAS_BITS'(NUM_REGS);

    logic nWrLevel, nWrRise, nWrFall;
    logic nRdLevel, nRdRise, nRdFall;
    logic nCsLevel, nCsRise, nCsFall;
    logic finLevel, finRise, finFall;

    ag32gbd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_syncWr (
        .clk_i(sys_clock), .rst_ni(sys_resetn), .d_i(Cart_nWR),
        .level_o(nWrLevel), .rise_o(nWrRise), .fall_o(nWrFall));
    ag32gbd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_syncRd (
        .clk_i(sys_clock), .rst_ni(sys_resetn), .d_i(Cart_nRD),
        .level_o(nRdLevel), .rise_o(nRdRise), .fall_o(nRdFall));
    ag32gbd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_syncCs (
        .clk_i(sys_clock), .rst_ni(sys_resetn), .d_i(Cart_nCS),
        .level_o(nCsLevel), .rise_o(nCsRise), .fall_o(nCsFall));
    ag32gbd_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncFin (
        .clk_i(sys_clock), .rst_ni(sys_resetn), .d_i(Sig_CamCaptureFinish),
        .level_o(finLevel), .rise_o(finRise), .fall_o(finFall));

    logic                      sel;
    logic [REG_ALIAS_BITS-1:0] off;
    logic                      isReg;
    logic                      regWrite;
    logic                      fifoPush;
    logic [9:0]                pushAddr;

    assign sel      = (Cart_a[15:13] == CART_RAM_A15_13) && !Cart_nCS && (Ram_bank_id == REG_BANK_ID);
    assign off      = Cart_a[REG_ALIAS_BITS-1:0];
    assign isReg    = off < NUM_REGS_OFF;
    assign regWrite = nWrFall && sel && isReg;
    assign fifoPush = nWrFall && sel && !isReg;
    assign pushAddr = {3'b000, off} - 10'(NUM_REGS) + BRAM_BASE;

    logic [7:0] regs_q [NUM_REGS];

    // A capture-finish clear is applied after the CPU write so it wins a collision.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= 8'h00;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (regWrite && (off == REG_ALIAS_BITS'(k))) regs_q[k] <= Cart_d;
            end
            if (finRise) regs_q[0] <= 8'h00;
        end
    end

    logic [7:0] readByte;
    logic       outValid_q;
    logic [7:0] outData_q;

    always_comb begin
        readByte = 8'h00;
        for (int k = 0; k < NUM_REGS; k++) begin
            if ((off == REG_ALIAS_BITS'(k)) && (READBACK_ALL || (k == 0))) readByte = regs_q[k];
        end
    end

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            outValid_q <= 1'b0;
            outData_q  <= 8'h00;
        end else if (nCsRise) begin
            outValid_q <= 1'b0;
            outData_q  <= 8'h00;
        end else if (nCsFall && !nRdLevel && sel) begin
            outValid_q <= 1'b1;
            outData_q  <= readByte;
        end
    end

    logic [17:0]      fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
    logic [CNT_W-1:0] count_q;
    logic             fifoFull, fifoEmpty, pushOk, fifoPop;
    logic             overflow_q;

    assign fifoFull  = count_q == CNT_W'(FIFO_DEPTH);
    assign fifoEmpty = count_q == '0;
    assign pushOk    = fifoPush && !fifoFull;

    always_ff @(posedge sys_clock) begin
        if (pushOk) fifoMem_q[wrPtr_q] <= {pushAddr, Cart_d};
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (pushOk)  wrPtr_q <= wrPtr_q + 1'b1;
            if (fifoPop) rdPtr_q <= rdPtr_q + 1'b1;
            count_q <= count_q + CNT_W'(pushOk) - CNT_W'(fifoPop);
            if (fifoPush && fifoFull) overflow_q <= 1'b1;
        end
    end

    drain_state_t state_q, state_d;
    logic         req_q, req_d;
    logic [9:0]   addr_q, addr_d;
    logic [7:0]   data_q, data_d;

    always_ff @(posedge sys_clock or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= 10'h000;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        data_d  = data_q;
        fifoPop = 1'b0;
        unique case (state_q)
            IDLE: if (!fifoEmpty) begin
                fifoPop          = 1'b1;
                {addr_d, data_d} = fifoMem_q[rdPtr_q];
                req_d            = 1'b1;
                state_d          = REQ;
            end
            REQ: if (Bram_Ack) begin
                req_d   = 1'b0;
                data_d  = 8'h00;
                state_d = GAP;
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
        assign Reg_Flat[8*k +: 8] = regs_q[k];
    end

    assign Reg_OutputValid = outValid_q;
    assign Reg_OutputData  = outData_q;
    assign Bram_Req_Write  = req_q;
    assign Bram_Addr       = addr_q;
    assign Bram_Data       = data_q;
    assign Cam_Capture     = regs_q[0][0];
    assign Fifo_Overflow   = overflow_q;

    logic unusedBits;
    assign unusedBits = ^{Cart_a[12:REG_ALIAS_BITS], nWrLevel, nWrRise, nRdRise, nRdFall,
                          nCsLevel, finLevel, finFall};

endmodule
